// File: rtl/matrix_reader_if.sv
// Bundle of request, metadata, stream and BRAM read-port signals of the matrix reader.
interface matrix_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
);
  logic                  read_request;
  logic [2:0]            matrix_id;
  logic                  read_ready;
  logic [7:0]            actual_rows;
  logic [7:0]            actual_cols;
  logic [7:0]            matrix_name [0:7];
  logic                  meta_valid;
  logic                  meta_error;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;
  logic                  read_done;
  logic                  bram_rd_en;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_dout;

  // Reader side: issues BRAM reads, publishes metadata and the element stream.
  modport slave (
    input  read_request, matrix_id, data_ready, bram_dout,
    output read_ready, actual_rows, actual_cols, matrix_name, meta_valid, meta_error,
           data_out, data_valid, read_done, bram_rd_en, bram_addr
  );

  // Requester / consumer / BRAM side.
  modport master (
    output read_request, matrix_id, data_ready, bram_dout,
    input  read_ready, actual_rows, actual_cols, matrix_name, meta_valid, meta_error,
           data_out, data_valid, read_done, bram_rd_en, bram_addr
  );
endinterface

// File: rtl/matrix_reader.sv
// Matrix block reader: fetches metadata (rows/cols, 8 name bytes) and then
// streams rows*cols data words from BRAM through a 2-entry output FIFO.

// Base address of a matrix block inside the BRAM.
module matrix_address_getter #(
  parameter int BLOCK_SIZE = 1152,
  parameter int ADDR_WIDTH = 14
) (
  input  logic [2:0]            matrix_id_i,
  output logic [ADDR_WIDTH-1:0] base_addr_o
);
  assign base_addr_o = ADDR_WIDTH'(32'(matrix_id_i) * 32'(BLOCK_SIZE));
endmodule

module matrix_reader #(
  parameter int BLOCK_SIZE = 1152,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input logic             clk,
  input logic             rst,
  matrix_reader_if.slave  bus
);
  localparam logic [15:0] MAX_ELEMS = 16'(BLOCK_SIZE - 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_META,
    S_META_WAIT,
    S_DATA,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [1:0]            meta_idx_q;
  logic                  cap_meta_q;
  logic [1:0]            cap_idx_q;
  logic [7:0]            rows_q;
  logic [7:0]            cols_q;
  logic [7:0]            name_q [0:7];
  logic                  meta_valid_q;
  logic                  meta_error_q;
  logic [15:0]           issued_q;
  logic [15:0]           popped_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] fifo_mem_q [0:1];
  logic                  fifo_wr_q;
  logic                  fifo_rd_q;
  logic [1:0]            fifo_cnt_q;
  logic                  read_done_q;

  logic [ADDR_WIDTH-1:0] base_w;
  logic [15:0]           total_w;
  logic                  pop_w;
  logic [2:0]            occ_w;
  logic                  issue_w;
  logic                  rd_en_w;
  logic [ADDR_WIDTH-1:0] rd_addr_w;

  matrix_address_getter #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr (
    .matrix_id_i (bus.matrix_id),
    .base_addr_o (base_w)
  );

  // Element count is a full 16-bit product so oversized blocks are detected, not wrapped.
  assign total_w = 16'(rows_q) * 16'(cols_q);

  // Occupancy seen by the issue logic: stored words plus the word returning this cycle,
  // minus the one leaving now. Keeping it below 2 guarantees the FIFO never overflows.
  assign pop_w   = (state_q == S_DATA) && (fifo_cnt_q != 2'd0) && bus.data_ready;
  assign occ_w   = {1'b0, fifo_cnt_q} + {2'b0, inflight_q} - {2'b0, pop_w};
  assign issue_w = (state_q == S_DATA) && (issued_q < total_w) && (occ_w < 3'd2);

  // BRAM read strobe/address: three metadata reads, then flow-controlled data reads.
  always_comb begin
    rd_en_w   = 1'b0;
    rd_addr_w = '0;
    if (state_q == S_META) begin
      rd_en_w   = 1'b1;
      rd_addr_w = base_q + ADDR_WIDTH'(meta_idx_q);
    end else if (issue_w) begin
      rd_en_w   = 1'b1;
      rd_addr_w = base_q + ADDR_WIDTH'(3) + ADDR_WIDTH'(issued_q);
    end
  end

  assign bus.bram_rd_en  = rd_en_w;
  assign bus.bram_addr   = rd_addr_w;
  assign bus.read_ready  = (state_q == S_IDLE);
  assign bus.actual_rows = rows_q;
  assign bus.actual_cols = cols_q;
  assign bus.meta_valid  = meta_valid_q;
  assign bus.meta_error  = meta_error_q;
  assign bus.data_out    = fifo_mem_q[fifo_rd_q];
  assign bus.data_valid  = (state_q == S_DATA) && (fifo_cnt_q != 2'd0);
  assign bus.read_done   = read_done_q;

  for (genvar gi = 0; gi < 8; gi++) begin : g_name
    assign bus.matrix_name[gi] = name_q[gi];
  end

  // Control FSM, metadata capture and output FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      meta_idx_q   <= '0;
      cap_meta_q   <= 1'b0;
      cap_idx_q    <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      meta_valid_q <= 1'b0;
      meta_error_q <= 1'b0;
      issued_q     <= '0;
      popped_q     <= '0;
      inflight_q   <= 1'b0;
      fifo_wr_q    <= 1'b0;
      fifo_rd_q    <= 1'b0;
      fifo_cnt_q   <= '0;
      read_done_q  <= 1'b0;
      for (int k = 0; k < 8; k++) name_q[k] <= '0;
      for (int k = 0; k < 2; k++) fifo_mem_q[k] <= '0;
    end else begin
      read_done_q <= 1'b0;
      cap_meta_q  <= 1'b0;
      inflight_q  <= 1'b0;

      // A metadata word arrives the cycle after its read.
      if (cap_meta_q) begin
        case (cap_idx_q)
          2'd0: begin
            rows_q <= bus.bram_dout[DATA_WIDTH-1 -: 8];
            cols_q <= bus.bram_dout[DATA_WIDTH-9 -: 8];
          end
          2'd1: for (int k = 0; k < 4; k++) name_q[k] <= bus.bram_dout[DATA_WIDTH-1-8*k -: 8];
          default: for (int k = 0; k < 4; k++) name_q[k+4] <= bus.bram_dout[DATA_WIDTH-1-8*k -: 8];
        endcase
      end

      case (state_q)
        S_IDLE: begin
          if (bus.read_request) begin
            base_q       <= base_w;
            meta_valid_q <= 1'b0;
            meta_error_q <= 1'b0;
            meta_idx_q   <= '0;
            issued_q     <= '0;
            popped_q     <= '0;
            fifo_wr_q    <= 1'b0;
            fifo_rd_q    <= 1'b0;
            fifo_cnt_q   <= '0;
            state_q      <= S_META;
          end
        end
        S_META: begin
          cap_meta_q <= 1'b1;
          cap_idx_q  <= meta_idx_q;
          meta_idx_q <= meta_idx_q + 2'd1;
          if (meta_idx_q == 2'd2) state_q <= S_META_WAIT;
        end
        S_META_WAIT: begin
          meta_valid_q <= 1'b1;
          if (total_w > MAX_ELEMS) begin
            meta_error_q <= 1'b1;
            read_done_q  <= 1'b1;
            state_q      <= S_DONE;
          end else if (total_w == 16'd0) begin
            read_done_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          inflight_q <= issue_w;
          if (issue_w) issued_q <= issued_q + 16'd1;
          if (inflight_q) begin
            fifo_mem_q[fifo_wr_q] <= bus.bram_dout;
            fifo_wr_q             <= ~fifo_wr_q;
          end
          fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop_w};
          if (pop_w) begin
            fifo_rd_q <= ~fifo_rd_q;
            popped_q  <= popped_q + 16'd1;
            if (popped_q == total_w - 16'd1) begin
              read_done_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_reader.sv
// Directed + randomized bench for matrix_reader with a BRAM model and a
// block-level reference model of the expected reads, metadata and stream.
module tb_matrix_reader;
  logic clk;
  logic rst;

  matrix_reader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(14)) bus ();

  matrix_reader #(.BLOCK_SIZE(1152), .DATA_WIDTH(32), .ADDR_WIDTH(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: one-cycle read latency, junk on the bus when not read.
  logic [31:0] mem [0:16383];
  always @(posedge clk) bus.bram_dout <= bus.bram_rd_en ? mem[bus.bram_addr] : $urandom();

  int n_tests = 0;
  int n_fail  = 0;

  int          m_rows [0:7];
  int          m_cols [0:7];
  logic [63:0] m_name [0:7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writes one matrix block into the BRAM model and records its metadata.
  task automatic load(input int id, input int rows, input int cols, input logic [63:0] nm,
                      input bit seq);
    int base;
    base = id * 1152;
    m_rows[id] = rows;
    m_cols[id] = cols;
    m_name[id] = nm;
    mem[base]   = {8'(rows), 8'(cols), 16'h0};
    mem[base+1] = nm[63:32];
    mem[base+2] = nm[31:0];
    for (int k = 0; k < rows * cols && k < 1149; k++)
      mem[base+3+k] = seq ? 32'(10 + k) : $urandom();
  endtask

  // mode: 0 = ready always high, 1 = ready 1,0,0,1 pattern, 2 = random ready + junk requests.
  task automatic do_read(input int id, input int mode, input int abort_n);
    int          base, total, cyc, hs, max_out, stall_viol;
    int          first_hs, last_hs, meta_cyc, done_cyc, exp_reads, exp_elems, n_done, n_rd;
    bit          exp_err, prev_stall, done, aborted;
    logic [31:0] prev_out;
    logic [31:0] got_q [$];
    int          addr_q [$];
    logic [63:0] nm;

    base     = id * 1152;
    total    = m_rows[id] * m_cols[id];
    exp_err  = (total > 1149);
    hs = 0; max_out = 0; stall_viol = 0; first_hs = -1; last_hs = -1;
    meta_cyc = -1; done_cyc = -1; prev_stall = 0; prev_out = '0; done = 0; aborted = 0;

    tick();
    #1;
    chk("idle_read_ready", 32'(bus.read_ready), 32'd1);
    chk("idle_no_done", 32'(bus.read_done), 32'd0);
    bus.read_request = 1'b1;
    bus.matrix_id    = 3'(id);
    bus.data_ready   = 1'b1;
    tick();
    bus.read_request = 1'b0;
    bus.matrix_id    = 3'($urandom());
    cyc = 1;
    for (int guard = 0; guard < 4000; guard++) begin
      case (mode)
        0: bus.data_ready = 1'b1;
        1: bus.data_ready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        default: begin
          bus.data_ready   = 1'($urandom_range(0, 1));
          bus.read_request = 1'($urandom_range(0, 1));
          bus.matrix_id    = 3'($urandom());
        end
      endcase
      #1;
      if (cyc == 1) chk("meta_cleared_on_accept", 32'(bus.meta_valid), 32'd0);
      if (bus.meta_valid && meta_cyc < 0) meta_cyc = cyc;
      if (prev_stall && !(bus.data_valid && bus.data_out === prev_out)) stall_viol++;
      if (bus.bram_rd_en) addr_q.push_back(int'(bus.bram_addr));
      if (bus.data_valid && bus.data_ready) begin
        got_q.push_back(bus.data_out);
        hs++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (addr_q.size() > 3 && (addr_q.size() - 3 - hs) > max_out) max_out = addr_q.size() - 3 - hs;
      prev_stall = bus.data_valid && !bus.data_ready;
      prev_out   = bus.data_out;
      if (bus.read_done) begin
        bus.read_request = 1'b0;
        chk("no_valid_in_done", 32'(bus.data_valid), 32'd0);
        done_cyc = cyc;
        done = 1;
        break;
      end
      if (abort_n > 0 && hs == abort_n) begin
        aborted = 1;
        break;
      end
      tick();
      cyc++;
    end

    if (aborted) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("abort_read_ready", 32'(bus.read_ready), 32'd1);
      chk("abort_meta_valid", 32'(bus.meta_valid), 32'd0);
      chk("abort_meta_error", 32'(bus.meta_error), 32'd0);
      chk("abort_rows_cols", {16'h0, bus.actual_rows, bus.actual_cols}, 32'd0);
      chk("abort_name", {bus.matrix_name[0], bus.matrix_name[1], bus.matrix_name[2],
                         bus.matrix_name[3]} | {bus.matrix_name[4], bus.matrix_name[5],
                         bus.matrix_name[6], bus.matrix_name[7]}, 32'd0);
      chk("abort_data_valid", 32'(bus.data_valid), 32'd0);
      chk("abort_data_out", bus.data_out, 32'd0);
      chk("abort_bram_rd", {bus.bram_rd_en, 17'h0, bus.bram_addr}, 32'd0);
      chk("abort_read_done", 32'(bus.read_done), 32'd0);
      n_done = 0;
      n_rd   = 0;
      for (int k = 0; k < 6; k++) begin
        tick();
        #1;
        if (bus.read_done) n_done++;
        if (bus.bram_rd_en) n_rd++;
      end
      chk("abort_no_late_done", 32'(n_done), 32'd0);
      chk("abort_stays_idle", 32'(n_rd), 32'd0);
      return;
    end

    if (!done) begin
      chk("read_timeout", 32'd0, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      return;
    end

    nm = m_name[id];
    chk("meta_latency", 32'(meta_cyc), 32'd5);
    chk("meta_valid_held", 32'(bus.meta_valid), 32'd1);
    chk("rows", 32'(bus.actual_rows), 32'(m_rows[id] & 255));
    chk("cols", 32'(bus.actual_cols), 32'(m_cols[id] & 255));
    chk("name_hi", {bus.matrix_name[0], bus.matrix_name[1], bus.matrix_name[2],
                    bus.matrix_name[3]}, nm[63:32]);
    chk("name_lo", {bus.matrix_name[4], bus.matrix_name[5], bus.matrix_name[6],
                    bus.matrix_name[7]}, nm[31:0]);
    chk("meta_error", 32'(bus.meta_error), 32'(exp_err));

    exp_elems = exp_err ? 0 : total;
    exp_reads = 3 + exp_elems;
    chk("bram_read_count", 32'(addr_q.size()), 32'(exp_reads));
    for (int k = 0; k < exp_reads && k < addr_q.size(); k++)
      chk("bram_read_addr", 32'(addr_q[k]), 32'(base + k));
    chk("element_count", 32'(got_q.size()), 32'(exp_elems));
    for (int k = 0; k < exp_elems && k < got_q.size(); k++)
      chk("element_value", got_q[k], mem[base + 3 + k]);
    chk("stall_stability", 32'(stall_viol), 32'd0);
    chk("outstanding_le_2", 32'(max_out <= 2), 32'd1);
    if (exp_elems == 0) begin
      chk("short_done_cycle", 32'(done_cyc), 32'd5);
    end else begin
      chk("done_after_last", 32'(done_cyc), 32'(last_hs + 1));
      if (mode == 0) begin
        chk("first_element_cycle", 32'(first_hs), 32'd7);
        chk("back_to_back_stream", 32'(last_hs - first_hs), 32'(total - 1));
      end
    end
  endtask

  initial begin
    int rid, rrows, rcols, rmode;
    for (int k = 0; k < 16384; k++) mem[k] = '0;
    for (int k = 0; k < 8; k++) begin
      m_rows[k] = 0;
      m_cols[k] = 0;
      m_name[k] = '0;
    end
    rst = 1'b1;
    bus.read_request = 1'b0;
    bus.matrix_id    = 3'd0;
    bus.data_ready   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("reset_read_ready", 32'(bus.read_ready), 32'd1);
    chk("reset_meta", {30'h0, bus.meta_valid, bus.meta_error}, 32'd0);
    chk("reset_rows_cols", {16'h0, bus.actual_rows, bus.actual_cols}, 32'd0);
    chk("reset_data", {31'h0, bus.data_valid} | bus.data_out, 32'd0);
    chk("reset_bram_rd", {bus.bram_rd_en, 17'h0, bus.bram_addr}, 32'd0);
    chk("reset_read_done", 32'(bus.read_done), 32'd0);

    load(1, 2, 3, "MATRIX_A", 1'b1);
    do_read(1, 0, 0);
    do_read(1, 1, 0);

    load(0, 0, 5, "EMPTY_00", 1'b1);
    do_read(0, 0, 0);

    load(2, 40, 40, "TOO_BIG!", 1'b0);
    do_read(2, 0, 0);

    load(7, 4, 4, "MATRIX_7", 1'b0);
    do_read(7, 0, 5);
    do_read(7, 0, 0);

    load(3, 3, 2, "MAT_THRE", 1'b0);
    load(4, 2, 5, "MAT_FOUR", 1'b0);
    do_read(3, 0, 0);
    do_read(4, 0, 0);

    load(5, 28, 41, "EDGE_OK_", 1'b0);
    do_read(5, 2, 0);
    load(6, 46, 25, "EDGE_BAD", 1'b0);
    do_read(6, 0, 0);

    for (int it = 0; it < 8; it++) begin
      rid   = $urandom_range(0, 7);
      rrows = $urandom_range(0, 7);
      rcols = $urandom_range(0, 7);
      rmode = $urandom_range(0, 2);
      load(rid, rrows, rcols, {$urandom(), $urandom()}, 1'b0);
      do_read(rid, rmode, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
